mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single-port SoC memory (byte-masked writes, 1-cycle registered read) between the CPU and a second bus master, such as a UART boot loader or DMA engine. It accepts a request/ready handshake on each master port, picks one winner, replays the latched transaction onto the memory port, and returns read data with a one-cycle ready pulse. It sits between the masters and the Memory instance; IO decode stays outside, on the memory side.

## Interface
- ADDR_W, 32, byte-address width on all ports
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- m0_addr, m1_addr  in  ADDR_W  master byte address
- m0_wdata, m1_wdata  in  32  write data, already lane-aligned by the master
- m0_wmask, m1_wmask  in  4  byte write enables; nonzero means write request
- m0_rstrb, m1_rstrb  in  1  read request level
- m0_rdata, m1_rdata  out  32  both equal mem_rdata; valid only in that port's ready cycle
- m0_ready, m1_ready  out  1  one-cycle completion pulse
- mem_addr  out  ADDR_W  to memory
- mem_wdata  out  32  to memory
- mem_wmask  out  4  to memory
- mem_rstrb  out  1  to memory
- mem_rdata  in  32  from memory, registered, valid the cycle after mem_rstrb
- busy  out  1  high in ISSUE and RESP

## Operation
- Request per port: req = rstrb | (|wmask), held as a level until ready. A nonzero wmask marks a write; rstrb is ignored when wmask is nonzero.
- The latched transaction register holds grant (1 bit), addr, wdata, wmask, and is_read.
- States:
  - IDLE: if any req, choose a winner, latch its fields, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: drive mem_addr/mem_wdata from the latch. Drive mem_wmask = latched wmask, or mem_rstrb = is_read, for exactly this cycle. Go to RESP.
  - RESP: pulse m<grant>_ready. If the other port requests, latch it and go to ISSUE. Otherwise go to IDLE. The current grantee's still-asserted req is never considered in RESP.
- Arbitration in IDLE, round-robin: on a tie, the port not granted last wins. A lone requester always wins. last_grant is updated on every latch.
- Outside ISSUE: mem_wmask = 0, mem_rstrb = 0, and mem_addr/mem_wdata hold the latched values.
- Protocol violation: if a master drops or changes its request before ready, the latched transaction still completes and the ready pulse is still issued.

## Timing
- Reset values: state IDLE, last_grant = 1 (so m0 wins the first tie), latch cleared, all mem_* outputs 0, ready 0, busy 0.
- Latency: request first seen in cycle N (IDLE), memory strobe in N+1, ready and valid rdata in N+2.
- Back-to-back alternating masters: one access every 2 cycles via RESP→ISSUE.
- Same master repeating: one access every 3 cycles, because it returns to IDLE.
- Both requesting continuously: strict alternation, no starvation.
- Reset asserted mid-ISSUE: mem_wmask/mem_rstrb drop immediately (asynchronous) and no ready pulse is produced. The memory may or may not have captured the write; masters must reissue.
- Reset released: arbitration starts on the first clk edge with reset low.

## Configuration
- MEMARB_FIXED_PRIO_EN defined:
  - In IDLE, m0 always wins ties; last_grant is unused for IDLE decisions.
  - The RESP handoff to the other port still applies, so m1 is served whenever it is waiting when an m0 access completes.
- Undefined (default): round-robin as described above.

## Test plan
- Single read: m0 reads 0x0000_0010 (memory word 0xDEADBEEF) → mem_rstrb high at N+1, m0_ready at N+2, m0_rdata = 0xDEADBEEF, m1_ready stays 0.
- Byte write: m1 writes wmask 4'b0100, wdata 0x00AA0000 to 0x20 → mem_wmask = 4'b0100 for exactly one cycle at N+1, m1_ready at N+2; a later read of 0x20 returns byte 2 = 0xAA with other bytes unchanged.
- Simultaneous first requests after reset: both read → m0 granted first; m1 issued directly from RESP; ready pulses at N+2 (m0) and N+4 (m1).
- Continuous contention for 20 cycles: grants strictly alternate m0/m1 and each port receives 5 ready pulses. With MEMARB_FIXED_PRIO_EN, ordering starts m0 and still alternates.
- Reset mid-ISSUE of a write: reset asserted in the ISSUE cycle → mem_wmask = 0 that same cycle, no ready pulse, state IDLE, busy = 0.
- Early request drop: m1 read deasserted in cycle N+1 → mem_rstrb still at N+1 and m1_ready still at N+2.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port memory with a 1-cycle registered read.
// Round-robin by default; define MEMARB_FIXED_PRIO_EN to make m0 win every IDLE tie.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wmask,
  input  logic              m0_rstrb,
  output logic [31:0]       m0_rdata,
  output logic              m0_ready,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wmask,
  input  logic              m1_rstrb,
  output logic [31:0]       m1_rdata,
  output logic              m1_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  output logic              mem_rstrb,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_grant;
  logic              r_is_read;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wmask;

  logic              w_req0;
  logic              w_req1;
  logic              w_latch;
  logic              w_sel;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [31:0]       w_sel_wdata;
  logic [3:0]        w_sel_wmask;

  assign w_req0 = m0_rstrb | (|m0_wmask);
  assign w_req1 = m1_rstrb | (|m1_wmask);

`ifndef MEMARB_FIXED_PRIO_EN
  logic r_last_grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
    end else if (w_latch) begin
      r_last_grant <= w_sel;
    end
  end
`endif

  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_sel        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req0 || w_req1) begin
          w_latch      = 1'b1;
          w_state_next = S_ISSUE;
`ifdef MEMARB_FIXED_PRIO_EN
          w_sel = ~w_req0;
`else
          w_sel = (w_req0 && w_req1) ? ~r_last_grant : w_req1;
`endif
        end
      end
      S_ISSUE: w_state_next = S_RESP;
      S_RESP: begin
        // Only the other port is eligible; the grantee's req is still high this cycle.
        w_sel = ~r_grant;
        if (r_grant ? w_req0 : w_req1) begin
          w_latch      = 1'b1;
          w_state_next = S_ISSUE;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_sel_addr  = w_sel ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_sel ? m1_wdata : m0_wdata;
  assign w_sel_wmask = w_sel ? m1_wmask : m0_wmask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_grant   <= 1'b0;
      r_is_read <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wmask   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_latch) begin
        r_grant   <= w_sel;
        r_addr    <= w_sel_addr;
        r_wdata   <= w_sel_wdata;
        r_wmask   <= w_sel_wmask;
        r_is_read <= ~(|w_sel_wmask);
      end
    end
  end

  // Strobes decode straight from state so an async reset kills them immediately.
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wmask = (r_state == S_ISSUE) ? r_wmask : 4'b0000;
  assign mem_rstrb = (r_state == S_ISSUE) && r_is_read;

  assign m0_ready = (r_state == S_RESP) && !r_grant;
  assign m1_ready = (r_state == S_RESP) && r_grant;
  assign m0_rdata = mem_rdata;
  assign m1_rdata = mem_rdata;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized two-master traffic
// scored against a shadow memory and transaction-level latency/handoff rules.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_wmask;
  logic        m0_rstrb, m0_ready;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wmask;
  logic        m1_rstrb, m1_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory model: byte-masked writes, registered read, plus a backdoor load port.
  logic [31:0] mem [64];
  logic        bd_we = 1'b0;
  logic [5:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_idx] <= bd_data;
    end else begin
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    if (mem_rstrb) mem_rdata <= mem[mem_addr[7:2]];
  end

  task automatic clear_inputs();
    m0_addr = '0; m0_wdata = '0; m0_wmask = '0; m0_rstrb = 1'b0;
    m1_addr = '0; m1_wdata = '0; m1_wmask = '0; m1_rstrb = 1'b0;
  endtask

  task automatic set_port(input int p, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wmask, input logic rstrb);
    if (p == 0) begin
      m0_addr = addr; m0_wdata = wdata; m0_wmask = wmask; m0_rstrb = rstrb;
    end else begin
      m1_addr = addr; m1_wdata = wdata; m1_wmask = wmask; m1_rstrb = rstrb;
    end
  endtask

  task automatic bd_write(input int idx, input logic [31:0] data);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx[5:0]; bd_data = data;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({mem_wmask, mem_rstrb, m0_ready, m1_ready, busy} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_ctrl: got wmask=%b rstrb=%b rdy=%b%b busy=%b required all 0",
               mem_wmask, mem_rstrb, m0_ready, m1_ready, busy);
    end
    n_cmp++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_bus: got addr=%h wdata=%h required 0", mem_addr, mem_wdata);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle_busy: got %b required 0", busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_single_read();
    bd_write(4, 32'hDEADBEEF);
    @(negedge clk);
    set_port(0, 32'h10, 32'h0, 4'h0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (mem_rstrb !== 1'b1 || mem_addr !== 32'h10 || m0_ready !== 1'b0) begin
      n_err++;
      $display("FAIL read_issue: got rstrb=%b addr=%h rdy=%b required 1/00000010/0",
               mem_rstrb, mem_addr, m0_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (m0_ready !== 1'b1 || m1_ready !== 1'b0 || m0_rdata !== 32'hDEADBEEF || mem_rstrb !== 1'b0) begin
      n_err++;
      $display("FAIL read_resp: got rdy0=%b rdy1=%b rdata=%h rstrb=%b required 1/0/deadbeef/0",
               m0_ready, m1_ready, m0_rdata, mem_rstrb);
    end
    clear_inputs();
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || m0_ready !== 1'b0) begin
      n_err++;
      $display("FAIL read_done: got busy=%b rdy0=%b required 0/0", busy, m0_ready);
    end
    $display("test_single_read: rdata=%h", 32'hDEADBEEF);
  endtask

  task automatic test_byte_write();
    logic [31:0] exp_word;
    exp_word = (32'h11223344 & ~32'h00FF0000) | 32'h00AA0000;
    bd_write(8, 32'h11223344);
    @(negedge clk);
    set_port(1, 32'h20, 32'h00AA0000, 4'b0100, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (mem_wmask !== 4'b0100 || mem_addr !== 32'h20 || mem_wdata !== 32'h00AA0000) begin
      n_err++;
      $display("FAIL write_issue: got wmask=%b addr=%h wdata=%h required 0100/00000020/00aa0000",
               mem_wmask, mem_addr, mem_wdata);
    end
    @(negedge clk);
    n_cmp++;
    if (mem_wmask !== 4'b0000 || m1_ready !== 1'b1 || m0_ready !== 1'b0) begin
      n_err++;
      $display("FAIL write_resp: got wmask=%b rdy1=%b rdy0=%b required 0000/1/0",
               mem_wmask, m1_ready, m0_ready);
    end
    clear_inputs();
    @(negedge clk);
    set_port(1, 32'h20, 32'h0, 4'h0, 1'b1);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (m1_ready !== 1'b1 || m1_rdata !== exp_word) begin
      n_err++;
      $display("FAIL write_readback: got rdy=%b rdata=%h required 1/%h", m1_ready, m1_rdata, exp_word);
    end
    clear_inputs();
    @(negedge clk);
    $display("test_byte_write: readback expected %h", exp_word);
  endtask

  task automatic test_simultaneous();
    bd_write(1, 32'hA0A0A0A0);
    bd_write(2, 32'hB1B1B1B1);
    do_reset();
    set_port(0, 32'h04, 32'h0, 4'h0, 1'b1);
    set_port(1, 32'h08, 32'h0, 4'h0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (mem_rstrb !== 1'b1 || mem_addr !== 32'h04) begin
      n_err++;
      $display("FAIL simul_first_issue: got rstrb=%b addr=%h required 1/00000004", mem_rstrb, mem_addr);
    end
    @(negedge clk);
    n_cmp++;
    if (m0_ready !== 1'b1 || m1_ready !== 1'b0 || m0_rdata !== 32'hA0A0A0A0) begin
      n_err++;
      $display("FAIL simul_m0_resp: got rdy0=%b rdy1=%b rdata=%h required 1/0/a0a0a0a0",
               m0_ready, m1_ready, m0_rdata);
    end
    set_port(0, 32'h0, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (mem_rstrb !== 1'b1 || mem_addr !== 32'h08 || m0_ready !== 1'b0) begin
      n_err++;
      $display("FAIL simul_m1_issue: got rstrb=%b addr=%h rdy0=%b required 1/00000008/0",
               mem_rstrb, mem_addr, m0_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (m1_ready !== 1'b1 || m0_ready !== 1'b0 || m1_rdata !== 32'hB1B1B1B1) begin
      n_err++;
      $display("FAIL simul_m1_resp: got rdy1=%b rdy0=%b rdata=%h required 1/0/b1b1b1b1",
               m1_ready, m0_ready, m1_rdata);
    end
    clear_inputs();
    @(negedge clk);
    $display("test_simultaneous: m0 at N+2, m1 at N+4");
  endtask

  task automatic test_contention();
    int c0, c1;
    logic e0, e1;
    c0 = 0; c1 = 0;
    do_reset();
    set_port(0, 32'h04, 32'h0, 4'h0, 1'b1);
    set_port(1, 32'h08, 32'h0, 4'h0, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      // Expect one completion every 2 cycles, m0 first, strictly alternating.
      e0 = (k % 2 == 0) && ((k / 2) % 2 == 1);
      e1 = (k % 2 == 0) && ((k / 2) % 2 == 0);
      c0 += int'(m0_ready);
      c1 += int'(m1_ready);
      n_cmp++;
      if (m0_ready !== e0 || m1_ready !== e1) begin
        n_err++;
        $display("FAIL contention_cycle%0d: got rdy=%b%b required %b%b", k, m0_ready, m1_ready, e0, e1);
      end
    end
    n_cmp++;
    if (c0 != 5 || c1 != 5) begin
      n_err++;
      $display("FAIL contention_count: got m0=%0d m1=%0d required 5/5", c0, c1);
    end
    clear_inputs();
    repeat (3) @(negedge clk);
    $display("test_contention: m0=%0d m1=%0d ready pulses", c0, c1);
  endtask

  task automatic test_reset_mid_issue();
    @(negedge clk);
    set_port(0, 32'h30, 32'hCAFEF00D, 4'hF, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (mem_wmask !== 4'hF) begin
      n_err++;
      $display("FAIL midrst_pre: got wmask=%b required 1111", mem_wmask);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (mem_wmask !== 4'h0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_drop: got wmask=%b busy=%b required 0000/0", mem_wmask, busy);
    end
    clear_inputs();
    @(negedge clk);
    n_cmp++;
    if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_noready: got rdy=%b%b required 00", m0_ready, m1_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || m0_ready !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_after: got busy=%b rdy0=%b required 0/0", busy, m0_ready);
    end
    $display("test_reset_mid_issue done");
  endtask

  task automatic test_early_drop();
    @(negedge clk);
    set_port(1, 32'h10, 32'h0, 4'h0, 1'b1);
    @(negedge clk);
    clear_inputs();
    #1;
    n_cmp++;
    if (mem_rstrb !== 1'b1 || mem_addr !== 32'h10) begin
      n_err++;
      $display("FAIL drop_issue: got rstrb=%b addr=%h required 1/00000010", mem_rstrb, mem_addr);
    end
    @(negedge clk);
    n_cmp++;
    if (m1_ready !== 1'b1 || m1_rdata !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL drop_resp: got rdy1=%b rdata=%h required 1/deadbeef", m1_ready, m1_rdata);
    end
    @(negedge clk);
    $display("test_early_drop done");
  endtask

  task automatic test_random();
    logic [31:0] shadow [64];
    logic [31:0] a_addr [2];
    logic [31:0] a_wdata [2];
    logic [3:0]  a_wmask [2];
    logic [31:0] rd [2];
    bit          pend [2];
    bit          exp_pend [2];
    bit          rdy [2];
    int          treq [2];
    int          gap [2];
    int          exp_cyc [2];
    int          lat, n_done, idx;
    logic [31:0] w;
    n_done = 0;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      shadow[i] = w;
      bd_write(i, w);
    end
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; exp_pend[p] = 0; gap[p] = 0; treq[p] = 0; exp_cyc[p] = 0;
      a_addr[p] = '0; a_wdata[p] = '0; a_wmask[p] = '0;
    end
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      rdy[0] = m0_ready; rdy[1] = m1_ready;
      rd[0] = m0_rdata;  rd[1] = m1_rdata;
      n_cmp++;
      if (rdy[0] && rdy[1]) begin
        n_err++;
        $display("FAIL rnd_both_ready: cycle %0d got 11 required at most one", c);
      end
      for (int p = 0; p < 2; p++) begin
        if (exp_pend[p] && exp_cyc[p] == c) begin
          exp_pend[p] = 0;
          n_cmp++;
          if (!rdy[p]) begin
            n_err++;
            $display("FAIL rnd_handoff: cycle %0d port %0d got ready=0 required 1", c, p);
          end
        end
        if (rdy[p]) begin
          n_cmp++;
          if (!pend[p]) begin
            n_err++;
            $display("FAIL rnd_spurious: cycle %0d port %0d got ready=1 required 0", c, p);
          end else begin
            lat = c - treq[p];
            idx = int'(a_addr[p][7:2]);
            if (lat < 2 || lat > 4) begin
              n_err++;
              $display("FAIL rnd_latency: port %0d got %0d cycles required 2..4", p, lat);
            end
            if (a_wmask[p] == 4'h0) begin
              n_cmp++;
              if (rd[p] !== shadow[idx]) begin
                n_err++;
                $display("FAIL rnd_rdata: port %0d addr %h got %h required %h", p, a_addr[p], rd[p], shadow[idx]);
              end
            end else begin
              for (int b = 0; b < 4; b++)
                if (a_wmask[p][b]) shadow[idx][8*b +: 8] = a_wdata[p][8*b +: 8];
            end
            $display("rnd txn port=%0d %s addr=%h lat=%0d", p, (a_wmask[p] == 0) ? "RD" : "WR", a_addr[p], lat);
            n_done++;
            pend[p] = 0;
            gap[p] = $urandom_range(1, 3);
            set_port(p, 32'h0, 32'h0, 4'h0, 1'b0);
          end
        end else if (pend[p] && (c - treq[p]) > 6) begin
          n_cmp++;
          n_err++;
          $display("FAIL rnd_timeout: port %0d waited %0d cycles required <= 4", p, c - treq[p]);
          pend[p] = 0;
          gap[p] = 1;
          set_port(p, 32'h0, 32'h0, 4'h0, 1'b0);
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          if (gap[p] > 0) gap[p]--;
          else if ($urandom_range(0, 9) < 6) begin
            a_addr[p]  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            a_wdata[p] = $urandom;
            a_wmask[p] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            pend[p] = 1;
            treq[p] = c;
            set_port(p, a_addr[p], a_wdata[p], a_wmask[p], a_wmask[p] == 4'h0);
          end
        end
      end
      // A completion with the other port waiting must hand straight over to it.
      for (int p = 0; p < 2; p++)
        if (rdy[p] && pend[1-p] && treq[1-p] <= c) begin
          exp_pend[1-p] = 1;
          exp_cyc[1-p]  = c + 2;
        end
    end
    n_cmp++;
    if (n_done < 200) begin
      n_err++;
      $display("FAIL rnd_progress: got %0d transactions required >= 200", n_done);
    end
    clear_inputs();
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_byte_write();
    test_simultaneous();
    test_contention();
    test_reset_mid_issue();
    test_early_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
